// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard events from the pipeline into the sequencer, and stall/flush controls back out.
// master = pipeline side, slave = hazard controller side.
interface riscv_hazard_ctrl_if;
    logic       i_riscv_hc_icache_stall;
    logic       i_riscv_hc_dcache_stall;
    logic       i_riscv_hc_mdu_busy;
    logic       i_riscv_hc_loaduse;
    logic       i_riscv_hc_branchtaken_e;
    logic       i_riscv_hc_gototrap_m;
    logic [1:0] i_riscv_hc_returnfromtrap_m;
    logic       o_riscv_hc_stall_f;
    logic       o_riscv_hc_stall_d;
    logic       o_riscv_hc_stall_e;
    logic       o_riscv_hc_stall_m;
    logic       o_riscv_hc_flush_d;
    logic       o_riscv_hc_flush_e;
    logic       o_riscv_hc_flush_m;
    logic       o_riscv_hc_flush_w;
    logic [1:0] o_riscv_hc_state;
    logic       o_riscv_hc_timeout;

    modport master (
        output i_riscv_hc_icache_stall, i_riscv_hc_dcache_stall, i_riscv_hc_mdu_busy,
               i_riscv_hc_loaduse, i_riscv_hc_branchtaken_e, i_riscv_hc_gototrap_m,
               i_riscv_hc_returnfromtrap_m,
        input  o_riscv_hc_stall_f, o_riscv_hc_stall_d, o_riscv_hc_stall_e, o_riscv_hc_stall_m,
               o_riscv_hc_flush_d, o_riscv_hc_flush_e, o_riscv_hc_flush_m, o_riscv_hc_flush_w,
               o_riscv_hc_state, o_riscv_hc_timeout
    );

    modport slave (
        input  i_riscv_hc_icache_stall, i_riscv_hc_dcache_stall, i_riscv_hc_mdu_busy,
               i_riscv_hc_loaduse, i_riscv_hc_branchtaken_e, i_riscv_hc_gototrap_m,
               i_riscv_hc_returnfromtrap_m,
        output o_riscv_hc_stall_f, o_riscv_hc_stall_d, o_riscv_hc_stall_e, o_riscv_hc_stall_m,
               o_riscv_hc_flush_d, o_riscv_hc_flush_e, o_riscv_hc_flush_m, o_riscv_hc_flush_w,
               o_riscv_hc_state, o_riscv_hc_timeout
    );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline stall/flush sequencer: zero-cycle combinational controls, post-trap drain, stall watchdog.
// RISCV_HC_PERF_EN adds memstall/mdustall/trap event counters.
module riscv_hazard_ctrl #(
    parameter int DRAIN_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                 i_riscv_hc_clk,
    input  logic                 i_riscv_hc_rst,
    riscv_hazard_ctrl_if.slave   hc
`ifdef RISCV_HC_PERF_EN
    ,
    output logic [31:0]          o_riscv_hc_memstall_cnt,
    output logic [31:0]          o_riscv_hc_mdustall_cnt,
    output logic [31:0]          o_riscv_hc_trap_cnt
`endif
);

    localparam int DW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DLOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [15:0] WD_LAST = 16'(STALL_TIMEOUT - 1);
    localparam logic [15:0] WD_SAT  = 16'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MEM   = 2'd1,
        ST_MDU   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [15:0]     wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic trap, rule_mem, rule_mdu;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w;

    always_comb begin
        trap     = hc.i_riscv_hc_gototrap_m | (|hc.i_riscv_hc_returnfromtrap_m);
        rule_mem = 1'b0;
        rule_mdu = 1'b0;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        flush_w  = 1'b0;
        state_d  = ST_RUN;
        drain_d  = drain_q;

        if (trap) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
            state_d = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_RUN;
            drain_d = DW'(DLOAD);
        end else if (state_q == ST_DRAIN) begin
            // Hold fetch and bubble decode while the trap-vector fetch settles.
            stall_f = 1'b1;
            flush_d = 1'b1;
            if (drain_q == '0) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_DRAIN;
                drain_d = drain_q - 1'b1;
            end
        end else if (hc.i_riscv_hc_dcache_stall) begin
            rule_mem = 1'b1;
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            state_d  = ST_MEM;
        end else if (hc.i_riscv_hc_mdu_busy) begin
            rule_mdu = 1'b1;
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
            state_d  = ST_MDU;
        end else if (hc.i_riscv_hc_branchtaken_e) begin
            // D holds a wrong-path instruction, so any load-use on it is moot.
            stall_f = hc.i_riscv_hc_icache_stall;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hc.i_riscv_hc_loaduse) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (hc.i_riscv_hc_icache_stall) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end

        // Watchdog saturates one past the trigger value so it fires once per stall episode.
        if (stall_e && !trap) begin
            wd_d = (wd_q == WD_SAT) ? wd_q : wd_q + 16'd1;
        end else begin
            wd_d = 16'd0;
        end
        timeout_d = stall_e && (wd_q == WD_LAST);
    end

    always_ff @(posedge i_riscv_hc_clk) begin
        if (i_riscv_hc_rst) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            wd_q      <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign hc.o_riscv_hc_stall_f = stall_f & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_stall_d = stall_d & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_stall_e = stall_e & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_stall_m = stall_m & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_flush_d = flush_d & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_flush_e = flush_e & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_flush_m = flush_m & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_flush_w = flush_w & ~i_riscv_hc_rst;
    assign hc.o_riscv_hc_state   = i_riscv_hc_rst ? 2'd0 : state_q;
    assign hc.o_riscv_hc_timeout = timeout_q & ~i_riscv_hc_rst;

`ifdef RISCV_HC_PERF_EN
    logic [31:0] memstall_q, mdustall_q, trapcnt_q;

    always_ff @(posedge i_riscv_hc_clk) begin
        if (i_riscv_hc_rst) begin
            memstall_q <= 32'd0;
            mdustall_q <= 32'd0;
            trapcnt_q  <= 32'd0;
        end else begin
            memstall_q <= memstall_q + {31'd0, rule_mem};
            mdustall_q <= mdustall_q + {31'd0, rule_mdu};
            trapcnt_q  <= trapcnt_q + {31'd0, trap};
        end
    end

    assign o_riscv_hc_memstall_cnt = memstall_q;
    assign o_riscv_hc_mdustall_cnt = mdustall_q;
    assign o_riscv_hc_trap_cnt     = trapcnt_q;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl: priority table, drain sequencing and watchdog.
module tb_riscv_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec  = 0;
    int   errs = 0;

    riscv_hazard_ctrl_if hc_if ();

`ifdef RISCV_HC_PERF_EN
    logic [31:0] memstall_cnt, mdustall_cnt, trap_cnt;
`endif

    riscv_hazard_ctrl #(
        .DRAIN_CYCLES (2),
        .STALL_TIMEOUT(8)
    ) dut (
        .i_riscv_hc_clk(clk),
        .i_riscv_hc_rst(rst),
        .hc            (hc_if.slave)
`ifdef RISCV_HC_PERF_EN
        ,
        .o_riscv_hc_memstall_cnt(memstall_cnt),
        .o_riscv_hc_mdustall_cnt(mdustall_cnt),
        .o_riscv_hc_trap_cnt    (trap_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
    wire [7:0] ctl = {hc_if.o_riscv_hc_stall_f, hc_if.o_riscv_hc_stall_d,
                      hc_if.o_riscv_hc_stall_e, hc_if.o_riscv_hc_stall_m,
                      hc_if.o_riscv_hc_flush_d, hc_if.o_riscv_hc_flush_e,
                      hc_if.o_riscv_hc_flush_m, hc_if.o_riscv_hc_flush_w};
    wire [1:0] st = hc_if.o_riscv_hc_state;
    wire       to = hc_if.o_riscv_hc_timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {icache, dcache, mdu, loaduse, branch, gototrap}
    task automatic drive(input logic [5:0] v);
        {hc_if.i_riscv_hc_icache_stall, hc_if.i_riscv_hc_dcache_stall,
         hc_if.i_riscv_hc_mdu_busy, hc_if.i_riscv_hc_loaduse,
         hc_if.i_riscv_hc_branchtaken_e, hc_if.i_riscv_hc_gototrap_m} = v;
        hc_if.i_riscv_hc_returnfromtrap_m = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(6'b010000);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            vec++;
            if ({ctl, st, to} !== 11'd0) begin
                errs++;
                $display("FAIL reset_hold cycle %0d: got %b want 0", i, {ctl, st, to});
            end
        end
        tick();
        rst = 1'b0;
        #1;
        vec++;
        if ({ctl, st} !== {8'hF0, 2'd0}) begin
            errs++;
            $display("FAIL reset_release: got ctl=%b st=%0d want ctl=11110000 st=0", ctl, st);
        end
        tick();
        #1;
        vec++;
        if ({ctl, st} !== {8'hF0, 2'd1}) begin
            errs++;
            $display("FAIL reset_mem_state: got ctl=%b st=%0d want ctl=11110000 st=1", ctl, st);
        end
        drive(6'b000000);
        tick();
        #1;
        vec++;
        if ({ctl, st} !== {8'h00, 2'd0}) begin
            errs++;
            $display("FAIL reset_back_to_run: got ctl=%b st=%0d want ctl=0 st=0", ctl, st);
        end
    endtask

    task automatic test_mdu();
        for (int i = 0; i < 6; i++) begin
            drive((i < 5) ? 6'b001000 : 6'b000000);
            #1;
            vec++;
            if ({ctl, st} !== {((i < 5) ? 8'b1110_0010 : 8'h00), ((i == 0) ? 2'd0 : 2'd2)}) begin
                errs++;
                $display("FAIL mdu_stall cycle %0d: got ctl=%b st=%0d", i, ctl, st);
            end
            tick();
        end
        #1;
        vec++;
        if (st !== 2'd0) begin
            errs++;
            $display("FAIL mdu_exit: got st=%0d want 0", st);
        end
    endtask

    task automatic test_priority();
        logic [5:0] vin [8];
        logic [7:0] vexp [8];
        vin  = '{6'b000110, 6'b100110, 6'b000100, 6'b100000,
                 6'b011000, 6'b001110, 6'b010010, 6'b000000};
        vexp = '{8'b0000_1100, 8'b1000_1100, 8'b1100_0100, 8'b1000_1000,
                 8'b1111_0000, 8'b1110_0010, 8'b1111_0000, 8'b0000_0000};
        for (int i = 0; i < 8; i++) begin
            drive(vin[i]);
            #1;
            vec++;
            if (ctl !== vexp[i]) begin
                errs++;
                $display("FAIL priority[%0d] in=%b: got %b want %b", i, vin[i], ctl, vexp[i]);
            end
            tick();
        end
        drive(6'b000000);
        tick();
    endtask

    task automatic test_trap();
        drive(6'b000101);
        #1;
        vec++;
        if (ctl !== 8'b0000_1111) begin
            errs++;
            $display("FAIL trap_entry: got %b want 00001111", ctl);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(6'b000100);
            #1;
            vec++;
            if ({ctl, st} !== ((i < 2) ? {8'b1000_1000, 2'd3} : {8'b1100_0100, 2'd0})) begin
                errs++;
                $display("FAIL trap_drain cycle %0d: got ctl=%b st=%0d", i, ctl, st);
            end
            tick();
        end
        drive(6'b000000);
    endtask

    task automatic test_trap_in_drain();
        drive(6'b000001);
        tick();
        drive(6'b000000);
        tick();
        hc_if.i_riscv_hc_returnfromtrap_m = 2'b11;
        #1;
        vec++;
        if ({ctl, st} !== {8'b0000_1111, 2'd3}) begin
            errs++;
            $display("FAIL xret_in_drain: got ctl=%b st=%0d want 00001111 st=3", ctl, st);
        end
        tick();
        drive(6'b000000);
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++;
            if ({ctl, st} !== ((i < 2) ? {8'b1000_1000, 2'd3} : {8'h00, 2'd0})) begin
                errs++;
                $display("FAIL drain_restart cycle %0d: got ctl=%b st=%0d", i, ctl, st);
            end
            tick();
        end
    endtask

    task automatic test_watchdog();
        int pulses;
        pulses = 0;
        drive(6'b000000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            hc_if.i_riscv_hc_dcache_stall = (i <= 20) || (i >= 22 && i <= 29);
            #1;
            if (to === 1'b1) pulses++;
            vec++;
            if (to !== ((i == 9) || (i == 30))) begin
                errs++;
                $display("FAIL watchdog cycle %0d: got timeout=%b want %b", i, to, (i == 9) || (i == 30));
            end
            tick();
        end
        drive(6'b000000);
        #1;
        vec++;
        if (pulses != 2) begin
            errs++;
            $display("FAIL watchdog_pulses: got %0d want 2", pulses);
        end
`ifdef RISCV_HC_PERF_EN
        vec++;
        if (memstall_cnt !== 32'd28) begin
            errs++;
            $display("FAIL perf_memstall: got %0d want 28", memstall_cnt);
        end
`endif
    endtask

    initial begin
        drive(6'b000000);
        test_reset();
        test_mdu();
        test_priority();
        test_trap();
        test_trap_in_drain();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_ctrl.md
Name: riscv_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV64 pipeline.
- Drives the hold (stall) and flush controls of the F/D, D/E, E/M and M/W pipeline registers from these events: cache misses, multicycle MDU operations, load-use hazards, taken branches, and trap entry/return in M.
- Owns the post-trap drain sequence and a stall watchdog.

Parameters:
- DRAIN_CYCLES, 2: cycles fetch is held and decode bubbled after a trap redirect; 0 = no drain.
- STALL_TIMEOUT, 1024: consecutive E-stage stall cycles before o_riscv_hc_timeout pulses; must be >= 2.

Ports:
- i_riscv_hc_clk  in  1  clock; all state updates on rising edge.
- i_riscv_hc_rst  in  1  synchronous, active-high reset.
- i_riscv_hc_icache_stall  in  1  fetch miss pending.
- i_riscv_hc_dcache_stall  in  1  M-stage memory access pending.
- i_riscv_hc_mdu_busy  in  1  E-stage mul/div in progress.
- i_riscv_hc_loaduse  in  1  D-stage instruction needs a load result still in E.
- i_riscv_hc_branchtaken_e  in  1  E-stage redirect (branch/jump mispredict).
- i_riscv_hc_gototrap_m  in  1  trap entry from M.
- i_riscv_hc_returnfromtrap_m  in  2  xRET from M; nonzero = return.
- o_riscv_hc_stall_f/_d/_e/_m  out  1 each  1 = hold that stage's register (stall_m drives M/W enable, 1 = hold).
- o_riscv_hc_flush_d/_e/_m/_w  out  1 each  1 = clear the register feeding that stage.
- o_riscv_hc_state  out  2  registered state: RUN=0, MEM=1, MDU=2, DRAIN=3.
- o_riscv_hc_timeout  out  1  one-cycle watchdog pulse.

Behaviour:
- Stall/flush outputs are combinational from the registered state and the current inputs. Zero-cycle response: the hazard and its control appear in the same cycle.
- Reset: while i_riscv_hc_rst=1, all outputs are 0. Next edge: state=RUN, drain counter=0, watchdog counter=0, timeout=0. Reset mid-drain or mid-stall aborts to RUN.
- "trap" = gototrap_m | (returnfromtrap_m != 0). Priority in RUN/MEM/MDU, highest first:
  1. trap: flush_d, flush_e, flush_m, flush_w = 1; all stalls 0.
  2. dcache_stall: stall_f, stall_d, stall_e, stall_m = 1; no flush.
  3. mdu_busy: stall_f, stall_d, stall_e = 1; flush_m = 1.
  4. branchtaken_e: flush_d, flush_e = 1. If icache_stall is also 1, stall_f = 1 too.
  5. loaduse: stall_f, stall_d = 1; flush_e = 1.
  6. icache_stall: stall_f = 1; flush_d = 1.
  7. none: all outputs 0.
- Next state:
  - trap → DRAIN with counter = DRAIN_CYCLES-1 (→ RUN if DRAIN_CYCLES = 0).
  - else dcache_stall → MEM.
  - else mdu_busy → MDU.
  - else → RUN.
- DRAIN state: stall_f = 1, flush_d = 1; all other inputs ignored except trap.
  - Counter decrements each cycle; at 0 → RUN.
  - A trap during DRAIN is handled as rule 1 and reloads the counter.
- Watchdog:
  - 16-bit counter increments each cycle stall_e = 1; clears when stall_e = 0 or on trap.
  - When the count reaches STALL_TIMEOUT-1 while stall_e = 1, o_riscv_hc_timeout is registered high for one cycle.
  - The counter then saturates (no repeat pulse) until the stall releases.
- Simultaneous events:
  - dcache_stall + mdu_busy: rule 2 only.
  - branch + loaduse: branch wins, because the D instruction is wrong-path.
  - trap + any: trap wins; outstanding cache requests are aborted by the flush.

Optional Feature:
- RISCV_HC_PERF_EN defined: adds 32-bit outputs o_riscv_hc_memstall_cnt, o_riscv_hc_mdustall_cnt and o_riscv_hc_trap_cnt.
  - They count cycles with rule 2 active, cycles with rule 3 active, and trap events respectively.
  - Reset to 0 by i_riscv_hc_rst; wrap at 2^32.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles with dcache_stall = 1 → all outputs 0. After release: state = 0, stall_f/d/e/m = 1 in the same cycle, state = 1 on the next edge.
- mdu_busy high 5 cycles → stall_f/d/e = 1 and flush_m = 1 for exactly 5 cycles; state = 2 for 5 cycles, then 0.
- branchtaken_e = 1 with loaduse = 1 in the same cycle → flush_d = flush_e = 1, stall_d = 0. With icache_stall also 1 → stall_f = 1.
- gototrap_m pulse, DRAIN_CYCLES = 2 → trap cycle has flush_d/e/m/w = 1. Next 2 cycles: state = 3, stall_f = 1, flush_d = 1, and a loaduse input is ignored. Then state = 0.
- returnfromtrap_m = 2'b11 during DRAIN → flushes reassert and the drain restarts for 2 more cycles.
- STALL_TIMEOUT = 8, dcache_stall held 20 cycles → exactly one timeout pulse, asserted the cycle after the 8th stall cycle. After release and 8 more stall cycles → a second pulse. With RISCV_HC_PERF_EN: memstall_cnt = 28.
